// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter_if
// Description : Display-fetch, host and RAM bus bundle for vram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic [7:0]        host_wait_max;

  // master: requesters plus the RAM itself; slave: the arbiter
  modport master (
    output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
    input  disp_valid, disp_data, host_ack, host_rdata, ram_addr, ram_we, ram_wdata,
           host_wait_max
  );

  modport slave (
    input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, ram_rdata,
    output disp_valid, disp_data, host_ack, host_rdata, ram_addr, ram_we, ram_wdata,
           host_wait_max
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Single-port frame-buffer RAM arbiter. Display fetches have
//               absolute priority and fixed 3-cycle latency; the host is
//               served in free cycles and its worst blocked wait is recorded.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  vram_arbiter_if.slave   bus
);

  localparam logic [1:0] c_tag_none = 2'd0;
  localparam logic [1:0] c_tag_disp = 2'd1;
  localparam logic [1:0] c_tag_host = 2'd2;
  localparam logic [7:0] c_wait_sat = 8'hFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_tag1;
  logic [1:0]        r_tag2;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;
  logic [7:0]        r_wait_cnt;
  logic [7:0]        r_wait_max;

  logic w_host_grant;
  logic w_host_blocked;

  assign w_host_grant   = (r_state == S_IDLE) && bus.host_req && !bus.disp_req;
  assign w_host_blocked = (r_state == S_IDLE) && bus.host_req &&  bus.disp_req;

  // Tag pipeline: r_tag1 travels with the RAM address, r_tag2 with ram_rdata,
  // and the valid/ack flops form the third and final stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tag1       <= c_tag_none;
      r_tag2       <= c_tag_none;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= '0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
      r_wait_cnt   <= '0;
      r_wait_max   <= '0;
    end else begin
      r_ram_we <= 1'b0;
      r_tag1   <= c_tag_none;
      if (bus.disp_req) begin
        r_ram_addr <= bus.disp_addr;
        r_tag1     <= c_tag_disp;
      end else if (w_host_grant) begin
        r_ram_addr <= bus.host_addr;
        r_ram_we   <= bus.host_we;
        r_tag1     <= c_tag_host;
        if (bus.host_we) begin
          r_ram_wdata <= bus.host_wdata;
        end
      end

      r_tag2       <= r_tag1;
      r_disp_valid <= (r_tag2 == c_tag_disp);
      r_host_ack   <= (r_tag2 == c_tag_host);
      if (r_tag2 == c_tag_disp) begin
        r_disp_data <= bus.ram_rdata;
      end
      if (r_tag2 == c_tag_host) begin
        r_host_rdata <= bus.ram_rdata;
      end

      case (r_state)
        S_IDLE: if (w_host_grant) r_state <= S_BUSY;
        S_BUSY: if (r_host_ack)   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_host_grant) begin
        if (r_wait_cnt > r_wait_max) begin
          r_wait_max <= r_wait_cnt;
        end
        r_wait_cnt <= '0;
      end else if (w_host_blocked && (r_wait_cnt != c_wait_sat)) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
    end
  end

  assign bus.ram_addr      = r_ram_addr;
  assign bus.ram_we        = r_ram_we;
  assign bus.ram_wdata     = r_ram_wdata;
  assign bus.disp_valid    = r_disp_valid;
  assign bus.disp_data     = r_disp_data;
  assign bus.host_ack      = r_host_ack;
  assign bus.host_rdata    = r_host_rdata;
  assign bus.host_wait_max = r_wait_max;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Randomized and directed self-checking bench for vram_arbiter
//               against a cycle-scheduled transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  logic clk;
  logic rst_n;
  vram_arbiter_if vif ();

  vram_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(int a);
    if (a == 'h0123) return 8'hA5;
    return 8'((a * 29) ^ (a >> 8));
  endfunction

  // synchronous-read, read-first frame buffer
  logic [7:0] ram [0:32767];
  bit         ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32768; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (vif.ram_we) begin
      ram[vif.ram_addr] <= vif.ram_wdata;
    end
    vif.ram_rdata <= ram[vif.ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: shadow memory plus per-cycle expectation slots
  int         cyc = 0;
  logic [7:0] mm [0:32767];
  int         m_free;
  int         m_wait;
  int         m_max;
  bit         exp_dv [8];
  logic [7:0] exp_dd [8];
  bit         exp_ha [8];
  bit         exp_rd [8];
  logic [7:0] exp_hr [8];
  bit         exp_we [8];
  logic [14:0] exp_wa [8];
  logic [7:0] exp_wd [8];

  int n_dv = 0, n_ack = 0, n_we = 0;
  logic [7:0] last_rdata;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      exp_dv[i] = 0; exp_ha[i] = 0; exp_rd[i] = 0; exp_we[i] = 0;
    end
  endtask

  task automatic model_eval();
    int s1, s3;
    bit host_idle;
    s1 = (cyc + 1) % 8;
    s3 = (cyc + 3) % 8;
    if (!rst_n) begin
      model_clear();
      m_wait = 0; m_max = 0; m_free = cyc + 1;
      return;
    end
    host_idle = (cyc >= m_free);
    if (vif.disp_req) begin
      exp_dv[s3] = 1;
      exp_dd[s3] = mm[vif.disp_addr];
      if (host_idle && vif.host_req && m_wait < 255) m_wait++;
    end else if (host_idle && vif.host_req) begin
      if (vif.host_we) begin
        mm[vif.host_addr] = vif.host_wdata;
        exp_we[s1] = 1; exp_wa[s1] = vif.host_addr; exp_wd[s1] = vif.host_wdata;
      end
      exp_ha[s3] = 1;
      exp_rd[s3] = !vif.host_we;
      exp_hr[s3] = mm[vif.host_addr];
      m_free = cyc + 4;
      if (m_wait > m_max) m_max = m_wait;
      m_wait = 0;
    end
  endtask

  task automatic compare();
    int s;
    s = cyc % 8;
    check("disp_valid", 32'(vif.disp_valid), 32'(exp_dv[s]));
    if (exp_dv[s]) check("disp_data", 32'(vif.disp_data), 32'(exp_dd[s]));
    check("host_ack", 32'(vif.host_ack), 32'(exp_ha[s]));
    if (exp_ha[s] && exp_rd[s]) check("host_rdata", 32'(vif.host_rdata), 32'(exp_hr[s]));
    check("ram_we", 32'(vif.ram_we), 32'(exp_we[s]));
    if (exp_we[s]) begin
      check("ram_addr", 32'(vif.ram_addr), 32'(exp_wa[s]));
      check("ram_wdata", 32'(vif.ram_wdata), 32'(exp_wd[s]));
    end
    check("wait_max", 32'(vif.host_wait_max), 32'(m_max));
    exp_dv[s] = 0; exp_ha[s] = 0; exp_rd[s] = 0; exp_we[s] = 0;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
    if (vif.disp_valid) n_dv++;
    if (vif.ram_we) n_we++;
    if (vif.host_ack) begin
      n_ack++;
      last_rdata = vif.host_rdata;
      vif.host_req = 1'b0;
    end
  endtask

  task automatic host_start(input bit we, input logic [14:0] addr, input logic [7:0] wd);
    vif.host_req   = 1'b1;
    vif.host_we    = we;
    vif.host_addr  = addr;
    vif.host_wdata = wd;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_dv"},    32'(vif.disp_valid), 32'd0);
    check({tag, "_ack"},   32'(vif.host_ack), 32'd0);
    check({tag, "_we"},    32'(vif.ram_we), 32'd0);
    check({tag, "_addr"},  32'(vif.ram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(vif.ram_wdata), 32'd0);
    check({tag, "_dd"},    32'(vif.disp_data), 32'd0);
    check({tag, "_hr"},    32'(vif.host_rdata), 32'd0);
    check({tag, "_max"},   32'(vif.host_wait_max), 32'd0);
  endtask

  initial begin
    int dv0, ack0, we0;
    for (int i = 0; i < 32768; i++) mm[i] = init_val(i);
    model_clear();
    m_free = 0; m_wait = 0; m_max = 0;
    rst_n = 1'b0;
    vif.disp_req = 1'b0; vif.disp_addr = '0;
    vif.host_req = 1'b0; vif.host_we = 1'b0; vif.host_addr = '0; vif.host_wdata = '0;
    @(negedge clk);
    step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step(); step();

    // single display fetch
    dv0 = n_dv;
    vif.disp_req = 1'b1; vif.disp_addr = 15'h0123;
    step();
    vif.disp_req = 1'b0;
    repeat (5) step();
    check("single_fetch_count", 32'(n_dv - dv0), 32'd1);

    // display burst on addresses 0..7
    dv0 = n_dv; we0 = n_we;
    for (int a = 0; a < 8; a++) begin
      vif.disp_req = 1'b1; vif.disp_addr = 15'(a);
      step();
    end
    vif.disp_req = 1'b0;
    repeat (4) step();
    check("burst_count", 32'(n_dv - dv0), 32'd8);
    check("burst_no_write", 32'(n_we - we0), 32'd0);

    // host write then read-back at the top address
    ack0 = n_ack; we0 = n_we;
    host_start(1'b1, 15'h7FFF, 8'h3C);
    repeat (6) step();
    check("hw_ack_count", 32'(n_ack - ack0), 32'd1);
    check("hw_we_count", 32'(n_we - we0), 32'd1);
    host_start(1'b0, 15'h7FFF, 8'h00);
    repeat (6) step();
    check("hr_ack_count", 32'(n_ack - ack0), 32'd2);
    check("hr_rdata", 32'(last_rdata), 32'h3C);

    // contention: 10 blocked cycles
    host_start(1'b0, 15'h0040, 8'h00);
    for (int i = 0; i < 10; i++) begin
      vif.disp_req = 1'b1; vif.disp_addr = 15'(100 + i);
      step();
      check("contend_no_ack", 32'(vif.host_ack), 32'd0);
    end
    vif.disp_req = 1'b0;
    repeat (6) step();
    check("contend_max", 32'(vif.host_wait_max), 32'd10);

    // saturation: 300 blocked cycles
    ack0 = n_ack;
    host_start(1'b1, 15'h0041, 8'h77);
    for (int i = 0; i < 300; i++) begin
      vif.disp_req = 1'b1; vif.disp_addr = 15'(i);
      step();
    end
    check("starve_no_ack", 32'(n_ack - ack0), 32'd0);
    vif.disp_req = 1'b0;
    repeat (6) step();
    check("sat_ack", 32'(n_ack - ack0), 32'd1);
    check("sat_max", 32'(vif.host_wait_max), 32'd255);

    // reset with a host access and a display fetch in flight
    dv0 = n_dv; ack0 = n_ack; we0 = n_we;
    host_start(1'b1, 15'h0050, 8'h99);
    step();
    vif.disp_req = 1'b1; vif.disp_addr = 15'h0123;
    step();
    vif.disp_req = 1'b0; vif.host_req = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_all_zero("midrst");
    host_start(1'b0, 15'h0123, 8'h00);
    repeat (6) step();
    check("midrst_dv", 32'(n_dv - dv0), 32'd0);
    check("midrst_ack", 32'(n_ack - ack0), 32'd1);
    check("midrst_we", 32'(n_we - we0), 32'd1);
    check("midrst_rdata", 32'(last_rdata), 32'hA5);

    // randomized traffic over a small address window to provoke reuse
    for (int i = 0; i < 2000; i++) begin
      vif.disp_req  = ($urandom_range(0, 99) < 55);
      vif.disp_addr = 15'($urandom_range(0, 63));
      if (!vif.host_req && ($urandom_range(0, 3) == 0))
        host_start(1'($urandom_range(0, 1)), 15'($urandom_range(0, 63)), 8'($urandom));
      rst_n = (i == 1000) ? 1'b0 : 1'b1;
      step();
    end
    vif.disp_req = 1'b0;
    rst_n = 1'b1;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
